// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_sb : register file with per-register busy scoreboard, self-clear   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             init_done,
  output logic [AW:0]      busy_cnt
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic run;
  logic wr_ok;
  logic rsv_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Out-of-range addresses and (optionally) register 0 are treated as absent.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  assign run    = (state_q == ST_RUN);
  assign wr_ok  = run && wr_en  && addr_ok(wr_addr);
  assign rsv_ok = run && rsv_en && addr_ok(rsv_addr);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      if (idx_q == c_last_idx) begin
        state_d = ST_RUN;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Clear is applied before set so a same-cycle reservation keeps the bit busy.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
      cnt_dec = busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
      cnt_inc = !busy_q[rsv_addr];
    end
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      if (state_q == ST_INIT) begin
        regs_d[idx_q] = '0;
      end else if (wr_ok) begin
        regs_d[wr_addr] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      idx_q      <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // The array holds no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] a);
    read_port = '0;
    if (run && addr_ok(a)) begin
      if (BYPASS && wr_ok && (a == wr_addr)) begin
        read_port = {1'b0, wr_data};
      end else begin
        read_port = {busy_q[a], regs_q[a]};
      end
    end
  endfunction

  assign {rs1_busy, rs1_data} = read_port(rs1_addr);
  assign {rs2_busy, rs2_data} = read_port(rs2_addr);
  assign init_done            = run;
  assign busy_cnt             = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_sb : scoreboard bench, DEPTH=32 bypass and DEPTH=20 no-bypass   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [31:0] wr_data;

  logic [31:0] rs1_data_o [2];
  logic [31:0] rs2_data_o [2];
  logic        rs1_busy_o [2];
  logic        rs2_busy_o [2];
  logic        init_done_o [2];
  logic [5:0]  busy_cnt_o [2];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_o[0]), .rs2_data(rs2_data_o[0]),
    .rs1_busy(rs1_busy_o[0]), .rs2_busy(rs2_busy_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .init_done(init_done_o[0]), .busy_cnt(busy_cnt_o[0])
  );

  regfile_sb #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut20 (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_o[1]), .rs2_data(rs2_data_o[1]),
    .rs1_busy(rs1_busy_o[1]), .rs2_busy(rs2_busy_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .init_done(init_done_o[1]), .busy_cnt(busy_cnt_o[1])
  );

  // Behavioural reference: index 0 is the DEPTH=32 instance, 1 the DEPTH=20.
  bit          m_run  [2];
  int          m_idx  [2];
  bit [63:0]   m_busy [2];
  logic [31:0] m_reg  [2][64];

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  function automatic int m_depth(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  function automatic bit m_zero(input int k);
    return (k == 0);
  endfunction

  function automatic bit m_byp(input int k);
    return (k == 0);
  endfunction

  function automatic bit m_valid(input int k, input logic [4:0] a);
    return (int'(a) < m_depth(k)) && !(m_zero(k) && (a == 5'd0));
  endfunction

  function automatic logic [32:0] m_read(input int k, input logic [4:0] a);
    if (!m_run[k] || !m_valid(k, a)) return 33'd0;
    if (m_byp(k) && wr_en && m_valid(k, wr_addr) && (a == wr_addr)) return {1'b0, wr_data};
    return {m_busy[k][a], m_reg[k][a]};
  endfunction

  function automatic logic [31:0] m_expect(input int k, input int f);
    logic [32:0] r1, r2;
    r1 = m_read(k, rs1_addr);
    r2 = m_read(k, rs2_addr);
    case (f)
      0:       return r1[31:0];
      1:       return r2[31:0];
      2:       return {31'd0, r1[32]};
      3:       return {31'd0, r2[32]};
      4:       return {31'd0, m_run[k]};
      default: return 32'($countones(m_busy[k]));
    endcase
  endfunction

  function automatic logic [31:0] dut_obs(input int sel);
    int k, f;
    k = sel / 6;
    f = sel % 6;
    case (f)
      0:       return rs1_data_o[k];
      1:       return rs2_data_o[k];
      2:       return {31'd0, rs1_busy_o[k]};
      3:       return {31'd0, rs2_busy_o[k]};
      4:       return {31'd0, init_done_o[k]};
      default: return {26'd0, busy_cnt_o[k]};
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic re, input logic [4:0] ra);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_run[k]  = 1'b0;
        m_idx[k]  = 0;
        m_busy[k] = '0;
      end else if (!m_run[k]) begin
        m_reg[k][m_idx[k]] = 32'd0;
        if (m_idx[k] == m_depth(k) - 1) begin
          m_run[k] = 1'b1;
          m_idx[k] = 0;
        end else begin
          m_idx[k] = m_idx[k] + 1;
        end
      end else begin
        if (we && m_valid(k, wa)) begin
          m_reg[k][wa]  = wd;
          m_busy[k][wa] = 1'b0;
        end
        if (re && m_valid(k, ra)) m_busy[k][ra] = 1'b1;
      end
    end
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2);
    string names [6];
    exp_t  e;
    names = '{"rs1_data", "rs2_data", "rs1_busy", "rs2_busy", "init_done", "busy_cnt"};
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; rs1_addr = a1; rs2_addr = a2;
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 6; f++) begin
        e.tag = $sformatf("%s.%s", (k == 0) ? "d32" : "d20", names[f]);
        e.sel = k * 6 + f;
        e.exp = m_expect(k, f);
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_eq(e.tag, dut_obs(e.sel), e.exp);
    end
    model_edge(r, we, wa, wd, re, ra);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_idx[k] = 0; m_busy[k] = '0;
      for (int i = 0; i < 64; i++) m_reg[k][i] = 32'd0;
    end
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then INIT with writes/reservations held on (both ignored).
    step(0, 1, 5'd3, 32'h1111_1111, 1, 5'd3, 5'd3, 5'd4);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd1, 5'd2);
    for (int i = 0; i < 34; i++)
      step(1, 1, 5'(i), 32'hA5A5_0000 + 32'(i), 1, 5'(i), 5'(i), 5'(31 - i));

    for (int i = 0; i < 32; i++)
      step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'(i), 5'(31 - i));

    // Write then read both ports; same-cycle write with bypass vs stored value.
    step(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd5, 5'd5);
    step(1, 1, 5'd7, 32'h0000_1234, 0, 5'd0, 5'd7, 5'd7);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd5);

    // Reservation, clear by writeback, and simultaneous reserve+write.
    step(1, 0, 5'd0, 32'd0, 1, 5'd3, 5'd3, 5'd3);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3, 5'd3);
    step(1, 1, 5'd3, 32'h0000_CAFE, 0, 5'd0, 5'd3, 5'd0);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3, 5'd3);
    step(1, 1, 5'd3, 32'h0000_BEEF, 1, 5'd3, 5'd3, 5'd3);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3, 5'd3);

    // Register 0 and an address beyond the 20-entry instance.
    step(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd0);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 5'd25, 32'h5555_5555, 1, 5'd25, 5'd25, 5'd25);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd25, 5'd24);

    // Fill the scoreboard, then reset for one cycle and restart the clear.
    for (int i = 1; i < 32; i++)
      step(1, 0, 5'd0, 32'd0, 1, 5'(i), 5'(i), 5'd3);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd31, 5'd19);
    step(0, 1, 5'd9, 32'h9999_9999, 1, 5'd9, 5'd9, 5'd31);
    for (int i = 0; i < 5; i++)
      step(1, 1, 5'(i), 32'h7777_0000, 1, 5'(i), 5'(i), 5'd31);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd1, 5'd2);
    for (int i = 0; i < 34; i++)
      step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'(i), 5'(i));

    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 59) != 0), 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers; legal range 2..64.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have derived parameter AW = $clog2(DEPTH): address width.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-008 SHALL have ports rs1_addr, rs2_addr  input  AW  read addresses.
REQ-009 SHALL have ports rs1_data, rs2_data  output  WIDTH  read data, combinational.
REQ-010 SHALL have ports rs1_busy, rs2_busy  output  1  scoreboard bit of the addressed register.
REQ-011 SHALL have ports wr_en input 1, wr_addr input AW, wr_data input WIDTH: writeback port.
REQ-012 SHALL have ports rsv_en input 1, rsv_addr input AW: destination reservation from issue.
REQ-013 SHALL have port init_done  output  1  high once the register array has been cleared.
REQ-014 SHALL have port busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-015 SHALL implement a two-state FSM, INIT and RUN; rst low forces INIT with clear index 0.
REQ-016 In INIT, SHALL write 0 to reg[idx] each cycle and increment idx; after writing idx = DEPTH-1, SHALL move to RUN on the next edge.
REQ-017 init_done SHALL be 0 in INIT and 1 in RUN; it rises on the DEPTH-th rising edge after rst is released.
REQ-018 In INIT: wr_en and rsv_en ignored; rs1_data/rs2_data = 0; rs1_busy/rs2_busy = 0.
REQ-019 In RUN, wr_en=1 SHALL write wr_data to reg[wr_addr] and clear busy[wr_addr] at the edge.
REQ-020 In RUN, rsv_en=1 SHALL set busy[rsv_addr] at the edge.
REQ-021 With rsv_en and wr_en to the same address in one cycle, busy SHALL end at 1 (reservation wins), and the data SHALL still be written.
REQ-022 With ZERO_REG=1, address 0: writes and reservations ignored, reads return 0, busy reads 0.
REQ-023 Addresses >= DEPTH: writes and reservations ignored, reads return 0 and busy 0.
REQ-024 With BYPASS=1, in RUN, wr_en=1 and rsN_addr==wr_addr (valid, non-zero-reg) SHALL give rsN_data=wr_data and rsN_busy=0 in the same cycle.
REQ-025 With BYPASS=0, reads SHALL return stored contents and stored busy bits only.
REQ-026 busy_cnt SHALL equal the population count of busy[] after each edge; it SHALL be maintained as a registered counter: +1 on set of a clear bit, -1 on clear of a set bit, unchanged when both occur or neither changes a bit.
REQ-027 Both read ports SHALL be independent; identical addresses on both SHALL return identical data.

Reset
REQ-028 On rst low at an edge: state=INIT, idx=0, all busy bits 0, busy_cnt=0, init_done=0, regardless of any operation in progress (including mid-INIT).
REQ-029 Register contents SHALL be guaranteed zero only after init_done=1; rst asserted mid-RUN SHALL restart the full clear sequence.

Verification
REQ-030 DEPTH=32: release rst, hold wr_en=1 -> init_done rises on edge 32; every register reads 0; no write lands during INIT.
REQ-031 RUN: write reg5=0xDEADBEEF, next cycle read rs1=5, rs2=5 -> both 0xDEADBEEF; same-cycle write to reg7=0x1234 with rs1_addr=7 -> rs1_data=0x1234, rs1_busy=0 (BYPASS=1); old value with BYPASS=0.
REQ-032 Reserve reg3 -> rs1_busy=1, busy_cnt=1; write reg3 -> busy 0, busy_cnt=0; reserve and write reg3 same cycle -> busy 1, busy_cnt=1, data updated.
REQ-033 ZERO_REG=1: write 0xFFFFFFFF and reserve reg0 -> reads 0, busy 0, busy_cnt unchanged.
REQ-034 Reserve regs 1..31 -> busy_cnt=31; assert rst one cycle -> busy_cnt=0, init_done=0, all busy 0, INIT restarts.
REQ-035 DEPTH=20: write/reserve addr 25 -> no effect; read addr 25 -> data 0, busy 0; init_done after 20 edges.
